// File: rtl/gfn_round_engine.sv
// gfn_round_engine
//
// Iterative generalised-Feistel round engine for an NWORDS x WORD_W block. Each clock applies
// one step of NWORDS-1 sub-rounds, so an operation takes STEPS = NROUNDS/(NWORDS-1) cycles.
// Round keys and S-box lookups come from external combinational units addressed by step_idx;
// decryption walks the steps in reverse and exactly inverts encryption.
//
// Word packing: word i lives at [WORD_W*(NWORDS-i)-1 -: WORD_W] (word 0 is the MSB word). The
// same MSB-first layout applies to key_in (k1 first) and to the S-box lane vectors.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin an operation; ignored while busy
//   mode_dec  in   1 = decrypt, 0 = encrypt; sampled with start
//   data_in   in   input block; sampled with start
//   key_in    in   round keys k1..k(N-1) for the current step_idx (combinational)
//   step_idx  out  step index presented to the key schedule (registered)
//   sbox_sel  out  S-box table select, equal to step_idx[0]
//   sbox_in   out  S-box lane inputs s0..s(N-2)
//   sbox_out  in   F(s_j) per lane (combinational)
//   busy      out  operation in progress
//   done      out  one-cycle pulse; data_out valid
//   data_out  out  result, held until the next accepted start
module gfn_round_engine #(
  parameter int unsigned WORD_W  = 9,
  parameter int unsigned NWORDS  = 4,
  parameter int unsigned NROUNDS = 93,
  parameter int unsigned STEP_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode_dec,
  input  logic [NWORDS*WORD_W-1:0]     data_in,
  input  logic [(NWORDS-1)*WORD_W-1:0] key_in,
  output logic [STEP_W-1:0]            step_idx,
  output logic                         sbox_sel,
  output logic [(NWORDS-1)*WORD_W-1:0] sbox_in,
  input  logic [(NWORDS-1)*WORD_W-1:0] sbox_out,
  output logic                         busy,
  output logic                         done,
  output logic [NWORDS*WORD_W-1:0]     data_out
);

  localparam int unsigned LANES = NWORDS - 1;
  localparam int unsigned STEPS = NROUNDS / LANES;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (NWORDS < 2) begin : g_chk_nwords
    $error("gfn_round_engine: NWORDS must be at least 2");
  end
  if ((NROUNDS % LANES) != 0 || STEPS < 1) begin : g_chk_nrounds
    $error("gfn_round_engine: NROUNDS must be a non-zero multiple of NWORDS-1");
  end
  if ((64'd1 << STEP_W) < 64'(STEPS)) begin : g_chk_step_w
    $error("gfn_round_engine: STEP_W too narrow for STEPS");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                   state_q;
  logic                     mode_q;
  logic [STEP_W-1:0]        step_q;
  logic                     busy_q;
  logic                     done_q;
  logic [NWORDS*WORD_W-1:0] data_out_q;
  logic [WORD_W-1:0]        x_q [NWORDS];

  logic [WORD_W-1:0]        key_w  [LANES];
  logic [WORD_W-1:0]        fout_w [LANES];
  logic [WORD_W-1:0]        y_enc  [NWORDS];
  logic [WORD_W-1:0]        y_dec  [NWORDS];
  logic [WORD_W-1:0]        y_w    [NWORDS];
  logic [NWORDS*WORD_W-1:0] y_packed;
  logic                     last_step;

  // Split the key and S-box return vectors into lanes; lane j carries k(j+1) and F(s_j).
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      key_w[j]  = key_in[WORD_W*(LANES-j)-1 -: WORD_W];
      fout_w[j] = sbox_out[WORD_W*(LANES-j)-1 -: WORD_W];
    end
  end

  // Encrypt step: every lane reads the current state, so the S-box lanes are independent.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      y_enc[j] = x_q[j+1] ^ key_w[j] ^ fout_w[j];
    end
    y_enc[LANES] = x_q[0];
  end

  // Decrypt step: lane i-1 is fed with y(i-1), so the lanes form a chain through the
  // external S-boxes (N-1 S-box delays in series).
  always_comb begin
    y_dec[0] = x_q[LANES];
    for (int i = 1; i < NWORDS; i++) begin
      y_dec[i] = key_w[i-1] ^ x_q[i-1] ^ fout_w[i-1];
    end
  end

  always_comb begin
    y_packed = '0;
    for (int i = 0; i < NWORDS; i++) begin
      y_w[i] = mode_q ? y_dec[i] : y_enc[i];
      y_packed[WORD_W*(NWORDS-i)-1 -: WORD_W] = y_w[i];
    end
  end

  always_comb begin
    sbox_in = '0;
    for (int j = 0; j < LANES; j++) begin
      sbox_in[WORD_W*(LANES-j)-1 -: WORD_W] = mode_q ? y_dec[j] : x_q[j];
    end
  end

  // Decrypt counts down to 0, encrypt counts up to STEPS-1.
  assign last_step = mode_q ? (step_q == '0) : (step_q == LAST_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < NWORDS; i++) begin
              x_q[i] <= data_in[WORD_W*(NWORDS-i)-1 -: WORD_W];
            end
            mode_q  <= mode_dec;
            step_q  <= mode_dec ? LAST_STEP : '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          for (int i = 0; i < NWORDS; i++) begin
            x_q[i] <= y_w[i];
          end
          if (last_step) begin
            // step_idx deliberately stays on the final index while idle.
            data_out_q <= y_packed;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else begin
            step_q <= mode_q ? (step_q - 1'b1) : (step_q + 1'b1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign step_idx = step_q;
  assign sbox_sel = step_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_gfn_round_engine.sv
module tb_gfn_round_engine;

  logic clk;
  logic rst;

  // Default-parameter engine (4 x 9, 31 steps) with random key/S-box tables.
  logic        start_a, mode_a, sel_a, busy_a, done_a;
  logic [35:0] din_a, dout_a;
  logic [26:0] key_a, sbin_a, sbout_a;
  logic [4:0]  step_a;

  // Single-step engine with zero keys and identity S-box.
  logic        start_b, mode_b, sel_b, busy_b, done_b;
  logic [35:0] din_b, dout_b;
  logic [26:0] key_b, sbin_b;
  logic [0:0]  step_b;

  // Parameter sweep: C is 2 x 8 (4 steps), D is 6 x 8 (2 steps); they share start/mode.
  logic        start_cd, mode_cd;
  logic        sel_c, busy_c, done_c, sel_d, busy_d, done_d;
  logic [15:0] din_c, dout_c;
  logic [7:0]  key_c, sbin_c, sbout_c;
  logic [1:0]  step_c;
  logic [47:0] din_d, dout_d;
  logic [39:0] key_d, sbin_d, sbout_d;
  logic [0:0]  step_d;

  int unsigned kt [3][32][5];
  int unsigned st [3][2][512];

  int n_checks = 0;
  int n_fail   = 0;

  gfn_round_engine u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode_dec(mode_a), .data_in(din_a), .key_in(key_a),
    .step_idx(step_a), .sbox_sel(sel_a), .sbox_in(sbin_a), .sbox_out(sbout_a), .busy(busy_a),
    .done(done_a), .data_out(dout_a)
  );

  gfn_round_engine #(.WORD_W(9), .NWORDS(4), .NROUNDS(3), .STEP_W(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode_dec(mode_b), .data_in(din_b), .key_in(key_b),
    .step_idx(step_b), .sbox_sel(sel_b), .sbox_in(sbin_b), .sbox_out(sbin_b), .busy(busy_b),
    .done(done_b), .data_out(dout_b)
  );

  gfn_round_engine #(.WORD_W(8), .NWORDS(2), .NROUNDS(4), .STEP_W(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_cd), .mode_dec(mode_cd), .data_in(din_c), .key_in(key_c),
    .step_idx(step_c), .sbox_sel(sel_c), .sbox_in(sbin_c), .sbox_out(sbout_c), .busy(busy_c),
    .done(done_c), .data_out(dout_c)
  );

  gfn_round_engine #(.WORD_W(8), .NWORDS(6), .NROUNDS(10), .STEP_W(1)) u_dut_d (
    .clk(clk), .rst(rst), .start(start_cd), .mode_dec(mode_cd), .data_in(din_d), .key_in(key_d),
    .step_idx(step_d), .sbox_sel(sel_d), .sbox_in(sbin_d), .sbox_out(sbout_d), .busy(busy_d),
    .done(done_d), .data_out(dout_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign key_b = '0;

  // External key schedule and S-box units, modelled as table lookups.
  always_comb begin
    key_a = '0;
    sbout_a = '0;
    for (int j = 0; j < 3; j++) begin
      key_a[9*(3-j)-1 -: 9]   = 9'(kt[0][step_a][j]);
      sbout_a[9*(3-j)-1 -: 9] = 9'(st[0][sel_a][sbin_a[9*(3-j)-1 -: 9]]);
    end
  end

  always_comb begin
    key_c   = 8'(kt[1][step_c][0]);
    sbout_c = 8'(st[1][sel_c][sbin_c]);
  end

  always_comb begin
    key_d = '0;
    sbout_d = '0;
    for (int j = 0; j < 5; j++) begin
      key_d[8*(5-j)-1 -: 8]   = 8'(kt[2][step_d][j]);
      sbout_d[8*(5-j)-1 -: 8] = 8'(st[2][sel_d][sbin_d[8*(5-j)-1 -: 8]]);
    end
  end

  // Whole-operation reference: run all steps of the Feistel rules on an array of words.
  function automatic logic [63:0] model(input int which, input bit dec, input logic [63:0] vin,
                                        input int n, input int ww, input int steps);
    int unsigned x [6];
    int unsigned y [6];
    logic [63:0] v;
    v = vin;
    for (int i = 0; i < 6; i++) begin
      x[i] = 0;
      y[i] = 0;
    end
    for (int i = n - 1; i >= 0; i--) begin
      x[i] = 32'(v) & ((32'd1 << ww) - 1);
      v = v >> ww;
    end
    for (int t = 0; t < steps; t++) begin
      int s;
      s = dec ? steps - 1 - t : t;
      if (dec) begin
        y[0] = x[n-1];
        for (int i = 1; i < n; i++) y[i] = kt[which][s][i-1] ^ x[i-1] ^ st[which][s%2][y[i-1]];
      end else begin
        for (int j = 0; j < n - 1; j++) y[j] = x[j+1] ^ kt[which][s][j] ^ st[which][s%2][x[j]];
        y[n-1] = x[0];
      end
      for (int i = 0; i < n; i++) x[i] = y[i];
    end
    v = '0;
    for (int i = 0; i < n; i++) v = (v << ww) | 64'(x[i]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One operation on engine A, started at the current negedge. Returns at the negedge where
  // done is seen, so a following call starts during the done cycle.
  task automatic run_a(input bit dec, input logic [35:0] din, input bit spam,
                       output logic [35:0] dout);
    int cyc;
    int seq_err;
    int exp_idx;
    seq_err = 0;
    mode_a  = dec;
    din_a   = din;
    start_a = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (!done_a && cyc <= 40) begin
      exp_idx = dec ? 31 - cyc : cyc - 1;
      if (!busy_a || step_a !== 5'(exp_idx) || sel_a !== exp_idx[0]) seq_err++;
      start_a = spam;
      if (spam) begin
        mode_a = 1'($urandom());
        din_a  = 36'({$urandom(), $urandom()});
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    chk("a_done_seen", done_a, 1);
    chk("a_latency", cyc - 1, 31);
    chk("a_step_seq", seq_err, 0);
    chk("a_busy_in_done", busy_a, 0);
    dout = dout_a;
  endtask

  task automatic run_cd(input bit dec, input logic [15:0] ic, input logic [47:0] id,
                        output logic [15:0] oc, output logic [47:0] od);
    int lc;
    int ld;
    oc = '0;
    od = '0;
    lc = -1;
    ld = -1;
    mode_cd  = dec;
    din_c    = ic;
    din_d    = id;
    start_cd = 1'b1;
    @(negedge clk);
    start_cd = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (done_c && lc < 0) begin
        lc = cyc - 1;
        oc = dout_c;
      end
      if (done_d && ld < 0) begin
        ld = cyc - 1;
        od = dout_d;
      end
      if (lc >= 0 && ld >= 0) break;
      @(negedge clk);
    end
    chk("c_latency", 64'(lc), 4);
    chk("d_latency", 64'(ld), 2);
  endtask

  typedef struct packed {
    logic        dec;
    logic [35:0] din;
    logic [35:0] dout;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    logic [35:0] orig, ct, pt, exp_sb;
    logic [63:0] ev;
    logic [15:0] oc, ec, rc;
    logic [47:0] od, ed, rd;

    // Single-step engine, keys 0, F = identity: hand-derived vectors.
    vecs[0] = '{1'b1, {9'd1, 9'd2, 9'd3, 9'd4}, {9'd4, 9'd5, 9'd7, 9'd4}};
    vecs[1] = '{1'b0, {9'd4, 9'd5, 9'd7, 9'd4}, {9'd1, 9'd2, 9'd3, 9'd4}};
    vecs[2] = '{1'b0, {9'd1, 9'd0, 9'd0, 9'd0}, {9'd1, 9'd0, 9'd0, 9'd1}};
    vecs[3] = '{1'b1, {9'd1, 9'd0, 9'd0, 9'd1}, {9'd1, 9'd0, 9'd0, 9'd0}};
    vecs[4] = '{1'b1, {9'h1ff, 9'd0, 9'd0, 9'd0}, {9'd0, 9'h1ff, 9'h1ff, 9'h1ff}};

    for (int w = 0; w < 3; w++) begin
      for (int s = 0; s < 32; s++)
        for (int l = 0; l < 5; l++) kt[w][s][l] = $urandom_range(w == 0 ? 511 : 255, 0);
      for (int t = 0; t < 2; t++)
        for (int v = 0; v < 512; v++) st[w][t][v] = $urandom_range(w == 0 ? 511 : 255, 0);
    end

    rst = 1'b1;
    start_a = 1'b0; mode_a = 1'b0; din_a = '0;
    start_b = 1'b0; mode_b = 1'b0; din_b = '0;
    start_cd = 1'b0; mode_cd = 1'b0; din_c = '0; din_d = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_data_out", dout_a, 0);
    chk("rst_step_idx", step_a, 0);
    chk("rst_sbox_sel", sel_a, 0);
    chk("rst_sbox_in", sbin_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_data_out_d", dout_d, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mode_b  = vecs[i].dec;
      din_b   = vecs[i].din;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      chk("b_busy_run", busy_b, 1);
      exp_sb = vecs[i].dec ? {vecs[i].dout[35:9], 9'd0} : {vecs[i].din[35:9], 9'd0};
      chk("b_sbox_in", sbin_b, exp_sb[35:9]);
      @(negedge clk);
      chk("b_done", done_b, 1);
      chk("b_busy_done", busy_b, 0);
      chk("b_data_out", dout_b, vecs[i].dout);
      @(negedge clk);
      chk("b_done_pulse", done_b, 0);
      chk("b_data_hold", dout_b, vecs[i].dout);
    end

    // Round trips on the default engine; decrypt starts in the encrypt's done cycle.
    for (int b = 0; b < 4; b++) begin
      orig = 36'({$urandom(), $urandom()});
      run_a(1'b0, orig, 1'b0, ct);
      ev = model(0, 1'b0, 64'(orig), 4, 9, 31);
      chk("a_encrypt", ct, ev);
      chk("a_b2b_done_cycle", done_a, 1);
      run_a(1'b1, ct, 1'b0, pt);
      chk("a_roundtrip", pt, orig);
    end
    @(negedge clk);
    chk("a_done_pulse", done_a, 0);
    chk("a_data_hold", dout_a, pt);
    chk("a_step_hold_dec", step_a, 0);

    // start held high with junk data throughout RUN must be ignored.
    orig = 36'({$urandom(), $urandom()});
    run_a(1'b0, orig, 1'b1, ct);
    ev = model(0, 1'b0, 64'(orig), 4, 9, 31);
    chk("a_spam_encrypt", ct, ev);
    @(negedge clk);
    chk("a_step_hold_enc", step_a, 30);
    chk("a_sel_hold_enc", sel_a, 0);
    chk("a_idle_busy", busy_a, 0);

    // Reset in the middle of a decrypt abandons it.
    mode_a  = 1'b1;
    din_a   = ct;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("a_mid_step", step_a, 20);
    chk("a_mid_busy", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy_a, 0);
    chk("mrst_done", done_a, 0);
    chk("mrst_data_out", dout_a, 0);
    chk("mrst_step_idx", step_a, 0);
    chk("mrst_sbox_sel", sel_a, 0);
    chk("mrst_sbox_in", sbin_a, 0);
    orig = 36'({$urandom(), $urandom()});
    run_a(1'b0, orig, 1'b0, ct);
    run_a(1'b1, ct, 1'b0, pt);
    chk("a_post_rst_roundtrip", pt, orig);
    start_a = 1'b0;

    // Parameter sweep round trips.
    for (int b = 0; b < 100; b++) begin
      oc = 16'($urandom());
      od = 48'({$urandom(), $urandom()});
      run_cd(1'b0, oc, od, ec, ed);
      ev = model(1, 1'b0, 64'(oc), 2, 8, 4);
      chk("c_encrypt", ec, ev);
      ev = model(2, 1'b0, 64'(od), 6, 8, 2);
      chk("d_encrypt", ed, ev);
      run_cd(1'b1, ec, ed, rc, rd);
      chk("c_roundtrip", rc, oc);
      chk("d_roundtrip", rd, od);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
